// File: rtl/dac_frame_rx_if.sv
// 3-wire DAC serial bus: sync (active low), sclk (idles high), sdata.
// master drives the bus (transmitter); slave listens (receiver/monitor).
interface dac_frame_rx_if;
    logic sclk;
    logic sdata;
    logic sync;

    modport master (
        output sclk,
        output sdata,
        output sync
    );

    modport slave (
        input sclk,
        input sdata,
        input sync
    );
endinterface

// File: rtl/dac_frame_rx.sv
// Listening end of the 3-wire DAC link: oversamples sync/sclk/sdata in the
// clk_100M domain, captures 24-bit MSB-first frames, decodes cmd/data and
// keeps shadow gain/offset copies.
// Ports: clk_100M, rst_n (async low), bus (slave modport),
//   frame_valid/frame_err/unknown_cmd one-cycle pulses,
//   cmd, data, gain, offset, frame_cnt registered results.
module dac_frame_rx #(
    parameter logic [7:0] DAC_LOAD_A = 8'd16,
    parameter logic [7:0] DAC_LOAD_B = 8'd36,
    parameter int         FRAME_BITS = 24
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    dac_frame_rx_if.slave        bus,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 unknown_cmd,
    output logic [7:0]           cmd,
    output logic [15:0]          data,
    output logic [15:0]          gain,
    output logic [15:0]          offset,
    output logic [15:0]          frame_cnt
);

    localparam logic [4:0] FB      = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX = 5'd31;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        ARMED,
        SHIFT
    } state_t;

    // Reset: asserted asynchronously, released on clk_100M.
    logic rst_m;
    logic rst_s;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            rst_m <= 1'b0;
            rst_s <= 1'b0;
        end else begin
            rst_m <= 1'b1;
            rst_s <= rst_m;
        end
    end

    // Bus synchronisers reset to the idle level. They leave reset two
    // cycles before the FSM, so a sync already low at release has
    // reached sync_s by the time WAIT_IDLE first looks at it.
    logic sclk_m, sclk_s, sclk_h;
    logic sync_m, sync_s, sync_h;
    logic sdata_m, sdata_s;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m  <= 1'b1;
            sclk_s  <= 1'b1;
            sclk_h  <= 1'b1;
            sync_m  <= 1'b1;
            sync_s  <= 1'b1;
            sync_h  <= 1'b1;
            sdata_m <= 1'b1;
            sdata_s <= 1'b1;
        end else begin
            sclk_m  <= bus.sclk;
            sclk_s  <= sclk_m;
            sclk_h  <= sclk_s;
            sync_m  <= bus.sync;
            sync_s  <= sync_m;
            sync_h  <= sync_s;
            sdata_m <= bus.sdata;
            sdata_s <= sdata_m;
        end
    end

    logic sclk_fall;
    logic sync_fall;
    logic sync_rise;

    assign sclk_fall = sclk_h & ~sclk_s;
    assign sync_fall = sync_h & ~sync_s;
    assign sync_rise = ~sync_h & sync_s;

    state_t      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        unk_q, unk_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic [15:0] gain_q, gain_d;
    logic [15:0] offset_q, offset_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk_100M or negedge rst_s) begin
        if (!rst_s) begin
            state_q     <= WAIT_IDLE;
            shift_q     <= '0;
            bcnt_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            unk_q       <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            gain_q      <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            unk_q       <= unk_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            gain_q      <= gain_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        unk_d       = 1'b0;
        cmd_d       = cmd_q;
        data_d      = data_q;
        gain_d      = gain_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            WAIT_IDLE: begin
                if (sync_s) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A coincident sclk fall is swallowed here.
                if (sync_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    bcnt_d  = '0;
                end
            end
            SHIFT: begin
                // sync rise has priority over a coincident sclk fall.
                if (sync_rise) begin
                    state_d = ARMED;
                    if (bcnt_q == FB) begin
                        valid_d     = 1'b1;
                        cmd_d       = shift_q[23:16];
                        data_d      = shift_q[15:0];
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        unique case (1'b1)
                            (shift_q[23:16] == DAC_LOAD_A):
                                gain_d = shift_q[15:0];
                            (shift_q[23:16] == DAC_LOAD_B):
                                offset_d = shift_q[15:0];
                            default:
                                unk_d = 1'b1;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    shift_d = {shift_q[22:0], sdata_s};
                    if (bcnt_q != CNT_MAX) begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign unknown_cmd = unk_q;
    assign cmd         = cmd_q;
    assign data        = data_q;
    assign gain        = gain_q;
    assign offset      = offset_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dac_frame_rx.sv
// Directed bench for dac_frame_rx: table of frames with expected results,
// plus hand sequences for coincident edges, glitch, reset and wrap.
module tb_dac_frame_rx;

    localparam time HALF = 500ns;
    localparam time GAP  = 500ns;

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic        frame_err;
    logic        unknown_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [15:0] gain;
    logic [15:0] offset;
    logic [15:0] frame_cnt;

    dac_frame_rx_if bus ();

    dac_frame_rx dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .unknown_cmd (unknown_cmd),
        .cmd         (cmd),
        .data        (data),
        .gain        (gain),
        .offset      (offset),
        .frame_cnt   (frame_cnt)
    );

    always #5ns clk_100M = ~clk_100M;

    int n_valid = 0;
    int n_err   = 0;
    int n_unk   = 0;
    int n_both  = 0;

    always @(negedge clk_100M) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (unknown_cmd) n_unk++;
        if (frame_valid && frame_err) n_both++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    task automatic send(input logic [23:0] w,
                        input int nbits,
                        input bit sim_start,
                        input bit sim_end);
        logic b;
        bus.sync = 1'b0;
        if (sim_start) begin
            bus.sclk = 1'b0;
            #HALF;
            bus.sclk = 1'b1;
        end
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 24) ? w[23 - i] : 1'b0;
            bus.sdata = b;
            #HALF;
            bus.sclk = 1'b0;
            #HALF;
            bus.sclk = 1'b1;
        end
        #HALF;
        if (sim_end) begin
            bus.sdata = 1'b0;
            bus.sclk  = 1'b0;
            bus.sync  = 1'b1;
            #HALF;
            bus.sclk = 1'b1;
        end else begin
            bus.sync = 1'b1;
        end
        #GAP;
    endtask

    typedef struct {
        logic [23:0] word;
        int          nbits;
        int          ev;
        int          ee;
        int          eu;
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [15:0] gain;
        logic [15:0] offset;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[6];
    int   v0, e0, u0;

    initial begin
        tbl[0] = '{24'h10_1234, 24, 1, 0, 0,
                   8'h10, 16'h1234, 16'h1234, 16'h0000, 16'd1};
        tbl[1] = '{24'h10_ABCD, 24, 1, 0, 0,
                   8'h10, 16'hABCD, 16'hABCD, 16'h0000, 16'd2};
        tbl[2] = '{24'h24_0F0F, 24, 1, 0, 0,
                   8'h24, 16'h0F0F, 16'hABCD, 16'h0F0F, 16'd3};
        tbl[3] = '{24'h10_FFFF, 23, 0, 1, 0,
                   8'h24, 16'h0F0F, 16'hABCD, 16'h0F0F, 16'd3};
        tbl[4] = '{24'h24_1111, 25, 0, 1, 0,
                   8'h24, 16'h0F0F, 16'hABCD, 16'h0F0F, 16'd3};
        tbl[5] = '{24'h55_0001, 24, 1, 0, 1,
                   8'h55, 16'h0001, 16'hABCD, 16'h0F0F, 16'd4};

        bus.sclk  = 1'b1;
        bus.sync  = 1'b1;
        bus.sdata = 1'b0;
        rst_n     = 1'b0;
        #100ns;
        rst_n = 1'b1;
        #200ns;

        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_unk", 32'(unknown_cmd), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_gain", 32'(gain), 0);
        chk("rst_offset", 32'(offset), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid;
            e0 = n_err;
            u0 = n_unk;
            send(tbl[k].word, tbl[k].nbits, 1'b0, 1'b0);
            chk($sformatf("t%0d_valid", k), n_valid - v0, tbl[k].ev);
            chk($sformatf("t%0d_err", k), n_err - e0, tbl[k].ee);
            chk($sformatf("t%0d_unk", k), n_unk - u0, tbl[k].eu);
            chk($sformatf("t%0d_cmd", k), 32'(cmd), 32'(tbl[k].cmd));
            chk($sformatf("t%0d_data", k), 32'(data), 32'(tbl[k].data));
            chk($sformatf("t%0d_gain", k), 32'(gain), 32'(tbl[k].gain));
            chk($sformatf("t%0d_offset", k), 32'(offset),
                32'(tbl[k].offset));
            chk($sformatf("t%0d_cnt", k), 32'(frame_cnt),
                32'(tbl[k].cnt));
        end

        // sync fall coincident with an sclk fall: that fall is dropped
        v0 = n_valid;
        e0 = n_err;
        send(24'h10_0042, 24, 1'b1, 1'b0);
        chk("simstart_valid", n_valid - v0, 1);
        chk("simstart_err", n_err - e0, 0);
        chk("simstart_gain", 32'(gain), 32'h0042);
        chk("simstart_cnt", 32'(frame_cnt), 5);

        // sync rise coincident with an sclk fall: that fall is dropped
        v0 = n_valid;
        e0 = n_err;
        send(24'h24_0077, 24, 1'b0, 1'b1);
        chk("simend_valid", n_valid - v0, 1);
        chk("simend_err", n_err - e0, 0);
        chk("simend_offset", 32'(offset), 32'h0077);
        chk("simend_cnt", 32'(frame_cnt), 6);

        // sync glitch with no sclk activity
        v0 = n_valid;
        e0 = n_err;
        bus.sync = 1'b0;
        #200ns;
        bus.sync = 1'b1;
        #GAP;
        chk("glitch_err", n_err - e0, 1);
        chk("glitch_valid", n_valid - v0, 0);
        chk("glitch_cnt", 32'(frame_cnt), 6);

        // reset after bit 10, released while sync still low
        v0 = n_valid;
        e0 = n_err;
        bus.sync = 1'b0;
        #HALF;
        for (int i = 0; i < 24; i++) begin
            if (i == 10) begin
                rst_n = 1'b0;
                #100ns;
                rst_n = 1'b1;
            end
            bus.sdata = i[0];
            #HALF;
            bus.sclk = 1'b0;
            #HALF;
            bus.sclk = 1'b1;
        end
        #HALF;
        bus.sync = 1'b1;
        #GAP;
        chk("midrst_valid", n_valid - v0, 0);
        chk("midrst_err", n_err - e0, 0);
        chk("midrst_gain", 32'(gain), 0);
        chk("midrst_offset", 32'(offset), 0);
        chk("midrst_cnt", 32'(frame_cnt), 0);
        v0 = n_valid;
        send(24'h24_8000, 24, 1'b0, 1'b0);
        chk("postrst_valid", n_valid - v0, 1);
        chk("postrst_offset", 32'(offset), 32'h8000);
        chk("postrst_cnt", 32'(frame_cnt), 1);

        // frame counter wrap
        @(negedge clk_100M);
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk_100M);
        release dut.frame_cnt_q;
        repeat (2) @(negedge clk_100M);
        chk("wrap_pre", 32'(frame_cnt), 32'hFFFF);
        v0 = n_valid;
        send(24'h10_0001, 24, 1'b0, 1'b0);
        chk("wrap_cnt", 32'(frame_cnt), 0);
        chk("wrap_valid", n_valid - v0, 1);
        chk("wrap_gain", 32'(gain), 32'h0001);

        chk("never_both", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
